// File: rtl/system_timer_pkg.sv
// Shared register map, bit positions and word-count helper for system_timer_v2.
package system_timer_pkg;

    localparam logic [3:0] ADDR_STATUS   = 4'd0;
    localparam logic [3:0] ADDR_CONTROL  = 4'd1;
    localparam logic [3:0] ADDR_PERIOD0  = 4'd2;
    localparam logic [3:0] ADDR_SNAP0    = 4'd6;
    localparam logic [3:0] ADDR_PRESCALE = 4'd10;

    localparam int unsigned STATUS_TO  = 0;
    localparam int unsigned STATUS_RUN = 1;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    function automatic int unsigned num_words(input int unsigned count_w);
        return count_w / 16;
    endfunction

endpackage

// File: rtl/system_timer_v2_if.sv
// Avalon-MM slave bundle for system_timer_v2: 4-bit word address, 16-bit data, read latency 1.
interface system_timer_v2_if;
    logic        chipselect;
    logic [3:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (output chipselect, address, write_n, writedata, input readdata);
    modport slave  (input chipselect, address, write_n, writedata, output readdata);
endinterface

// File: rtl/system_timer_prescaler.sv
// Tick divider for system_timer_v2; compiled only when SYSTEM_TIMER_PRESCALE_EN is defined.
// A PRESCALE value N yields one tick every N+1 running cycles.
`ifdef SYSTEM_TIMER_PRESCALE_EN
module system_timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       clear,
    input  logic [7:0] prescale,
    output logic       tick
);
    logic [7:0] pcount_q, pcount_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pcount_q <= '0;
        else       pcount_q <= pcount_d;
    end

    always_comb begin
        pcount_d = pcount_q;
        if (!run || clear)         pcount_d = '0;
        else if (pcount_q == '0)   pcount_d = prescale;
        else                       pcount_d = pcount_q - 8'd1;
    end

    assign tick = (pcount_q == '0);
endmodule
`endif

// File: rtl/system_timer_v2.sv
// Avalon-MM interval timer: programmable period, one-shot/continuous, snapshot, level irq.
// Define SYSTEM_TIMER_PRESCALE_EN to add the PRESCALE register and tick prescaler.
module system_timer_v2
    import system_timer_pkg::*;
#(
    parameter int unsigned        COUNT_W     = 32,
    parameter logic [COUNT_W-1:0] PERIOD_INIT = COUNT_W'(50_000_000 - 1),
    parameter bit                 RUN_INIT    = 1'b1,
    parameter bit                 CONT_INIT   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    system_timer_v2_if.slave bus,
    output logic             irq
);
    localparam int unsigned NW  = num_words(COUNT_W);
    localparam logic [3:0]  NW4 = 4'(NW);

    logic [COUNT_W-1:0] count_q, count_d, period_q, period_d, snap_q, snap_d;
    logic               to_q, to_d, run_q, run_d, ito_q, ito_d, cont_q, cont_d;
    logic [15:0]        readdata_q, rdata;
    logic [7:0]         prescale_val;
    logic               tick, timeout;
    logic               wr, wr_status, wr_control, wr_period, wr_snap;
    logic               in_period, in_snap;
    logic [3:0]         per_off, snap_off;

    assign wr         = bus.chipselect & ~bus.write_n;
    assign per_off    = bus.address - ADDR_PERIOD0;
    assign snap_off   = bus.address - ADDR_SNAP0;
    // Words at or above NW are unimplemented: they read 0 and ignore writes.
    assign in_period  = (bus.address >= ADDR_PERIOD0) && (per_off < NW4);
    assign in_snap    = (bus.address >= ADDR_SNAP0) && (snap_off < NW4);
    assign wr_status  = wr && (bus.address == ADDR_STATUS);
    assign wr_control = wr && (bus.address == ADDR_CONTROL);
    assign wr_period  = wr && in_period;
    assign wr_snap    = wr && in_snap;

`ifdef SYSTEM_TIMER_PRESCALE_EN
    logic [7:0] prescale_q;
    logic       wr_prescale;

    assign wr_prescale = wr && (bus.address == ADDR_PRESCALE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            prescale_q <= '0;
        else if (wr_prescale) prescale_q <= bus.writedata[7:0];
    end

    system_timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .run      (run_q),
        .clear    (wr_prescale),
        .prescale (prescale_q),
        .tick     (tick)
    );

    assign prescale_val = prescale_q;
`else
    assign tick         = 1'b1;
    assign prescale_val = 8'd0;
`endif

    assign timeout = run_q && tick && (count_q == '0);

    always_comb begin
        period_d = period_q;
        for (int unsigned w = 0; w < NW; w++) begin
            if (wr_period && (per_off == 4'(w))) period_d[w*16 +: 16] = bus.writedata;
        end

        count_d = count_q;
        if (wr_period)          count_d = period_d;
        else if (run_q && tick) count_d = timeout ? period_q : count_q - COUNT_W'(1);

        // Later assignments take priority: STOP over START, PERIOD write over everything.
        run_d = run_q;
        if (timeout)                                  run_d = cont_q;
        if (wr_control && bus.writedata[CTRL_START])  run_d = 1'b1;
        if (wr_control && bus.writedata[CTRL_STOP])   run_d = 1'b0;
        if (wr_period)                                run_d = 1'b0;

        to_d   = timeout | (to_q & ~wr_status);
        ito_d  = wr_control ? bus.writedata[CTRL_ITO]  : ito_q;
        cont_d = wr_control ? bus.writedata[CTRL_CONT] : cont_q;
        snap_d = wr_snap ? count_q : snap_q;
    end

    always_comb begin
        rdata = '0;
        if (bus.address == ADDR_STATUS) begin
            rdata[STATUS_TO]  = to_q;
            rdata[STATUS_RUN] = run_q;
        end else if (bus.address == ADDR_CONTROL) begin
            rdata[CTRL_ITO]  = ito_q;
            rdata[CTRL_CONT] = cont_q;
        end else if (bus.address == ADDR_PRESCALE) begin
            rdata[7:0] = prescale_val;
        end else if (in_period) begin
            for (int unsigned w = 0; w < NW; w++) begin
                if (per_off == 4'(w)) rdata = period_q[w*16 +: 16];
            end
        end else if (in_snap) begin
            for (int unsigned w = 0; w < NW; w++) begin
                if (snap_off == 4'(w)) rdata = snap_q[w*16 +: 16];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= PERIOD_INIT;
            period_q   <= PERIOD_INIT;
            snap_q     <= '0;
            to_q       <= 1'b0;
            run_q      <= RUN_INIT;
            ito_q      <= 1'b0;
            cont_q     <= CONT_INIT;
            readdata_q <= '0;
        end else begin
            count_q    <= count_d;
            period_q   <= period_d;
            snap_q     <= snap_d;
            to_q       <= to_d;
            run_q      <= run_d;
            ito_q      <= ito_d;
            cont_q     <= cont_d;
            readdata_q <= rdata;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = to_q & ito_q;

endmodule
